// File: rtl/strassen_l2_product_engine.sv
// Level-2 product responder: captures an NxN T/S operand pair on start and computes
// Q = T x S with an output-stationary MAC array (one k-slice per cycle). It then holds
// Q and done until start is withdrawn (4-phase handshake).
module strassen_l2_product_engine #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int QW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N*N*DW-1:0]   t_in,
  input  logic [N*N*DW-1:0]   s_in,
  output logic [N*N*QW-1:0]   q_out,
  output logic                done,
  output logic                busy
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * DW;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   k_d;
  logic            done_q;
  logic            busy_q;
  logic [DW-1:0]   t_q [N][N];
  logic [DW-1:0]   s_q [N][N];
  logic            capture;
  logic            mac_en;

  assign capture = (state_q == IDLE) && start;
  assign mac_en  = (state_q == MAC);
  assign k_d     = k_q + KW'(1);
  assign done    = done_q;
  assign busy    = busy_q;

  // Control FSM; the operand registers are loaded only on the capture edge, so the
  // initiator is free to change t_in/s_in afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          t_q[i][j] <= '0;
          s_q[i][j] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                t_q[i][j] <= t_in[(i*N+j)*DW +: DW];
                s_q[i][j] <= s_in[(i*N+j)*DW +: DW];
              end
            end
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          // start is deliberately ignored here: a started product always completes.
          if (k_q == K_LAST) begin
            k_q     <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            k_q <= k_d;
          end
        end
        DONE: begin
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic [PW-1:0] prod;
        logic [QW-1:0] term;
        logic [QW-1:0] acc_q;
        logic [QW-1:0] acc_d;

        assign prod = {{DW{1'b0}}, t_q[gi][k_q]} * {{DW{1'b0}}, s_q[k_q][gj]};

        // Fit the full-width product to the accumulator width (zero-extend or truncate).
        if (QW > PW) begin : g_ext
          assign term = {{(QW-PW){1'b0}}, prod};
        end else if (QW == PW) begin : g_same
          assign term = prod;
        end else begin : g_trunc
          assign term = prod[QW-1:0];
        end

        assign acc_d = acc_q + term;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            acc_q <= '0;
          end else if (capture) begin
            acc_q <= '0;
          end else if (mac_en) begin
            acc_q <= acc_d;
          end
        end

        assign q_out[(gi*N+gj)*QW +: QW] = acc_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_strassen_l2_product_engine.sv
// Self-checking bench for strassen_l2_product_engine: directed and random operand pairs
// checked against a plain matrix-product reference model.
module tb_strassen_l2_product_engine;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int QW = 16;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [N*N*DW-1:0]  t_in;
  logic [N*N*DW-1:0]  s_in;
  logic [N*N*QW-1:0]  q_out;
  logic               done;
  logic               busy;

  int total = 0;
  int bad   = 0;
  int tm [N][N];
  int sm [N][N];
  logic [N*N*QW-1:0] expq;
  logic [N*N*QW-1:0] zero_q;

  strassen_l2_product_engine #(.N(N), .DW(DW), .QW(QW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .t_in  (t_in),
    .s_in  (s_in),
    .q_out (q_out),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_q(input string tag, input logic [N*N*QW-1:0] expv);
    int fi;
    int fj;
    fi = 0;
    fj = 0;
    total++;
    assert (q_out === expv) else begin
      bad++;
      for (int e = N*N-1; e >= 0; e--)
        if (q_out[e*QW +: QW] !== expv[e*QW +: QW]) begin
          fi = e / N;
          fj = e % N;
        end
      $error("FAIL %s q(%0d,%0d) obs=%h exp=%h", tag, fi, fj,
             q_out[(fi*N+fj)*QW +: QW], expv[(fi*N+fj)*QW +: QW]);
    end
  endtask

  // Reference: Q = T x S from the operand tables, reduced modulo 2^QW.
  function automatic logic [N*N*QW-1:0] model();
    logic [N*N*QW-1:0] r;
    longint sum;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int k = 0; k < N; k++) sum += longint'(tm[i][k]) * longint'(sm[k][j]);
        r[(i*N+j)*QW +: QW] = QW'(sum % 65536);
      end
    return r;
  endfunction

  task automatic load();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        t_in[(i*N+j)*DW +: DW] = DW'(tm[i][j]);
        s_in[(i*N+j)*DW +: DW] = DW'(sm[i][j]);
      end
  endtask

  task automatic scramble();
    for (int w = 0; w < N*N*DW/32; w++) begin
      t_in[w*32 +: 32] = $urandom;
      s_in[w*32 +: 32] = $urandom;
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tm[i][j] = int'($urandom_range(0, 255));
        sm[i][j] = int'($urandom_range(0, 255));
      end
  endtask

  // Full 4-phase transaction: capture, wait for done, check, hold, withdraw.
  task automatic run_op(input string tag, input bit scr, input int hold);
    int cnt;
    load();
    expq = model();
    start = 1'b1;
    tick();
    chk({tag, "_busy_cap"}, int'(busy), 1);
    cnt = 0;
    while (!done && cnt < 20) begin
      if (scr) scramble();
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, cnt, N);
    chk({tag, "_busy_done"}, int'(busy), 0);
    chk_q({tag, "_q"}, expq);
    for (int h = 0; h < hold; h++) begin
      if (scr) scramble();
      tick();
      chk({tag, "_done_hold"}, int'(done), 1);
      chk_q({tag, "_q_hold"}, expq);
    end
    start = 1'b0;
    tick();
    chk({tag, "_done_fall"}, int'(done), 0);
    chk({tag, "_busy_idle"}, int'(busy), 0);
    chk_q({tag, "_q_after"}, expq);
    $display("txn %s latency=%0d q00=%h q77=%h", tag, cnt, q_out[0 +: QW], q_out[(N*N-1)*QW +: QW]);
  endtask

  initial begin
    int cnt;
    zero_q = '0;
    rst_n = 1'b0;
    start = 1'b0;
    t_in  = '0;
    s_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk_q("rst_q", zero_q);
    rst_n = 1'b1;
    tick();

    // 1: identity x ramp
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tm[i][j] = (i == j) ? 1 : 0;
        sm[i][j] = i*8 + j;
      end
    run_op("ident_ramp", 1'b0, 0);

    // 2: all 0xFF wraps to 0xF008
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tm[i][j] = 255;
        sm[i][j] = 255;
      end
    run_op("all_ff", 1'b0, 0);
    chk("all_ff_elem", int'(q_out[5*QW +: QW]), 'hF008);

    // 3: start held 5 cycles past done
    rand_ops();
    run_op("hold5", 1'b0, 5);

    // 4: reset pulse at MAC k=3
    rand_ops();
    load();
    start = 1'b1;
    tick();
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 0);
    chk_q("midrst_q", zero_q);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("txn midrst done=%0d busy=%0d", done, busy);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tm[i][j] = (i == j) ? 1 : 0;
        sm[i][j] = (i == j) ? 1 : 0;
      end
    run_op("post_rst_ident", 1'b0, 0);

    // 5: seven back-to-back products
    for (int m = 1; m <= 7; m++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          tm[i][j] = m + i;
          sm[i][j] = j;
        end
      run_op($sformatf("b2b_m%0d", m), 1'b0, 0);
    end

    // 6: operands scrambled every cycle after capture
    for (int r = 0; r < 4; r++) begin
      rand_ops();
      run_op($sformatf("scramble%0d", r), 1'b1, r);
    end

    // start dropped during MAC: done pulses for one cycle
    rand_ops();
    load();
    expq = model();
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("drop_latency", cnt, N);
    chk_q("drop_q", expq);
    tick();
    chk("drop_done_pulse", int'(done), 0);
    tick();
    chk("drop_stay_idle", int'(busy), 0);
    $display("txn drop_mid_mac latency=%0d done=%0d", cnt, done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
